// File: rtl/ponte_cmd_decoder.sv
// ponte_cmd_decoder: turns each HPS PIO request toggle into one valid/ready command to the zoom coprocessor, then returns an ack toggle and status byte.
// Define PONTE_TIMEOUT_EN to add a cmd_done watchdog (TIMEOUT_CYCLES); without it the block waits indefinitely.
module ponte_cmd_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [14:0] pio_in,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_opcode,
  output logic [10:0] cmd_operand,
  input  logic        cmd_done,
  input  logic        cmd_err,
  output logic [7:0]  status_out,
  output logic        busy
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTLE    = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    REPORT    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [14:0] sync_q [STAGES];
  logic [14:0] pio_sync;
  logic [2:0]  opcode_q, opcode_d;
  logic [10:0] operand_q, operand_d;
  logic        req_q, req_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        timeout_fire;
  logic        tmo_flag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pio_in;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign pio_sync = sync_q[STAGES-1];

`ifdef PONTE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
  logic          tmo_hit;

  assign tmo_hit      = (cnt_q >= CW'(TIMEOUT_CYCLES - 1));
  // A handshake or completion landing on the last cycle beats the watchdog.
  assign timeout_fire = tmo_hit && (((state_q == ISSUE) && !cmd_ready) ||
                                    ((state_q == WAIT_DONE) && !cmd_done));
  assign tmo_flag     = tmo_q;

  always_comb begin
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    if (state_q == SETTLE) begin
      cnt_d = '0;
      tmo_d = 1'b0;
    end else if ((state_q == ISSUE) || (state_q == WAIT_DONE)) begin
      if (!tmo_hit) cnt_d = cnt_q + CW'(1);
      if (timeout_fire) tmo_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign tmo_flag     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pio_sync[14] != ack_q) state_d = SETTLE;
      SETTLE:    if ((pio_sync[13:11] == 3'd0) || (pio_sync[13:12] == 2'b11)) state_d = REPORT;
                 else                                                         state_d = ISSUE;
      ISSUE:     if (cmd_ready)         state_d = WAIT_DONE;
                 else if (timeout_fire) state_d = REPORT;
      WAIT_DONE: if (cmd_done || timeout_fire) state_d = REPORT;
      REPORT:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_valid   = (state_q == ISSUE);
    cmd_opcode  = opcode_q;
    cmd_operand = operand_q;
    busy        = busy_q;
    status_out  = {1'b0, opcode_q, tmo_flag, err_q, busy_q, ack_q};
  end

  // Datapath registers; status is built only from these so HPS sees clean levels.
  always_comb begin
    opcode_d  = opcode_q;
    operand_d = operand_q;
    req_d     = req_q;
    ack_d     = ack_q;
    err_d     = err_q;
    busy_d    = (state_d != IDLE);
    case (state_q)
      SETTLE: begin
        opcode_d  = pio_sync[13:11];
        operand_d = pio_sync[10:0];
        req_d     = pio_sync[14];
        err_d     = (pio_sync[13:12] == 2'b11);
      end
      ISSUE:     if (timeout_fire) err_d = 1'b1;
      WAIT_DONE: if (cmd_done)          err_d = err_q | cmd_err;
                 else if (timeout_fire) err_d = 1'b1;
      REPORT:    ack_d = req_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opcode_q  <= '0;
      operand_q <= '0;
      req_q     <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      req_q     <= req_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

endmodule
